user_panel: RTL
===============

USER_PANEL -- requirements
Module: user_panel

Interface
REQ-001 SHALL have parameter WIDTH, default 4, bit width of selector, engine operand, result and LED bus.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable samples required to accept a button level change.
REQ-003 SHALL have parameter SATURATE, default 0; 0 = selector wraps, 1 = selector saturates.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, request timeout length (used only per REQ-025).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port inc_n  input  1  increment button, active-low, asynchronous to clk.
REQ-008 SHALL have port dec_n  input  1  decrement button, active-low, asynchronous to clk.
REQ-009 SHALL have port start_n  input  1  start button, active-low, asynchronous to clk.
REQ-010 SHALL have port req_o  output  1  request to compute engine.
REQ-011 SHALL have port n_o  output  WIDTH  operand for engine (current selector value).
REQ-012 SHALL have port ack_i  input  1  engine completion, single-cycle or level.
REQ-013 SHALL have port result_i  input  WIDTH  engine result, valid while ack_i high.
REQ-014 SHALL have port leds_n_o  output  WIDTH  LED drive, active-low (0 = lit).
REQ-015 SHALL have port busy_o  output  1  high while a request is outstanding.
REQ-016 SHALL have port err_o  output  1  sticky timeout flag.

Function
REQ-017 Each button SHALL pass a 2-FF synchroniser then a debouncer; debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples; glitches shorter are discarded.
REQ-018 A press event SHALL be a one-cycle pulse on debounced 1->0 transition; holding produces no further events.
REQ-019 FSM states IDLE, REQ; reset state IDLE.
REQ-020 In IDLE: inc event -> sel+1, dec event -> sel-1, both in same cycle -> sel unchanged; sel updates the cycle after the event.
REQ-021 Boundaries: inc at 2^WIDTH-1 -> 0 (SATURATE=0) or hold (SATURATE=1); dec at 0 -> 2^WIDTH-1 (SATURATE=0) or hold (SATURATE=1).
REQ-022 start event in IDLE -> REQ next cycle; req_o=1, busy_o=1, n_o=sel held stable until exit; start event coincident with inc/dec: start wins, sel unchanged.
REQ-023 inc/dec/start events and ack_i outside their valid state SHALL be ignored.
REQ-024 In REQ with ack_i=1: capture result_i, next cycle leds_n_o=~result, req_o=0, busy_o=0, err_o cleared, state IDLE.
REQ-025 Without timeout feature, REQ SHALL wait indefinitely for ack_i.
REQ-026 n_o SHALL equal sel at all times in IDLE.

Reset
REQ-027 rst sampled high SHALL next cycle set: state IDLE, sel 0, req_o 0, busy_o 0, err_o 0, leds_n_o all 1 (all off), debouncers to released (1) with counters 0.
REQ-028 rst during REQ SHALL abort the request; a late ack_i after reset is ignored.

Configuration
REQ-029 Macro USER_PANEL_TIMEOUT_EN defined: REQ counts cycles; at TIMEOUT_CYCLES without ack_i -> IDLE, req_o 0, leds_n_o all 0 (all lit), err_o 1 until next successful ack or reset; ack_i in the timeout cycle wins.
REQ-030 Macro undefined: no timeout counter synthesised, err_o tied 0.

Structure
REQ-031 Package user_panel_pkg SHALL hold the state enum typedef and default parameter constants.
REQ-032 Sub-module button_debounce (synchroniser, debounce counter, press pulse) SHALL be instantiated three times.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16)
REQ-033 Reset 10 cycles -> leds_n_o=1111, req_o=0, n_o=0, busy_o=0, err_o=0.
REQ-034 inc_n low 6 cycles, start_n low 6 cycles -> req_o=1, n_o=1; engine ack with result 2 -> leds_n_o=1101, req_o=0.
REQ-035 inc_n low 2 cycles only -> no event, n_o stays 0.
REQ-036 dec press at sel=0 -> n_o=15 (SATURATE=0) / n_o=0 (SATURATE=1); inc+dec events same cycle -> n_o unchanged.
REQ-037 With USER_PANEL_TIMEOUT_EN, start, no ack 16 cycles -> leds_n_o=0000, err_o=1, req_o=0; without macro req_o stays 1 after 100 cycles.
REQ-038 rst asserted while req_o=1, then ack_i pulse -> req_o=0, leds_n_o=1111, result not captured.

Source files
------------

// File: rtl/user_panel_pkg.sv
// user_panel_pkg: shared types and default parameter values for the user panel.
package user_panel_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  localparam int DEF_WIDTH           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_SATURATE        = 0;
  localparam int DEF_TIMEOUT_CYCLES  = 1024;

endpackage

// File: rtl/user_panel_debounce.sv
// button_debounce: 2-FF synchroniser, debounce counter and press pulse for
// one active-low push button. The debounced level idles at 1 (released).
module button_debounce
  import user_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Two flops bring the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples;
  // any sample matching the current level restarts the count, so short glitches die here.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/user_panel.sv
// user_panel: three debounced buttons drive a selector, issue requests to a
// compute engine and show the returned result on active-low LEDs.
// Optional request timeout enabled by defining USER_PANEL_TIMEOUT_EN.
module user_panel
  import user_panel_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SATURATE        = DEF_SATURATE,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_n,
  input  logic             dec_n,
  input  logic             start_n,
  output logic             req_o,
  output logic [WIDTH-1:0] n_o,
  input  logic             ack_i,
  input  logic [WIDTH-1:0] result_i,
  output logic [WIDTH-1:0] leds_n_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] SEL_MAX = '1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] leds;
  logic             inc_ev;
  logic             dec_ev;
  logic             start_ev;
  logic             timeout_hit;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk  (clk),
    .rst  (rst),
    .btn_n(inc_n),
    .press(inc_ev)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk  (clk),
    .rst  (rst),
    .btn_n(dec_n),
    .press(dec_ev)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk  (clk),
    .rst  (rst),
    .btn_n(start_n),
    .press(start_ev)
  );

`ifdef USER_PANEL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;
  logic          err;

  // Count cycles spent waiting in REQ; cleared whenever we are not waiting.
  always_ff @(posedge clk) begin
    if (rst || state != ST_REQ) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // An ack arriving in the final cycle beats the timeout.
  assign timeout_hit = (state == ST_REQ) && !ack_i && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Sticky error: set by a timeout, cleared by the next good ack or by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == ST_REQ) begin
      if (ack_i) begin
        err <= 1'b0;
      end else if (timeout_hit) begin
        err <= 1'b1;
      end
    end
  end

  assign err_o = err;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign err_o          = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: start leaves IDLE, ack or timeout returns from REQ.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_ev) state_next = ST_REQ;
      ST_REQ:  if (ack_i || timeout_hit) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request and busy are both simply "waiting in REQ".
  always_comb begin
    req_o  = 1'b0;
    busy_o = 1'b0;
    if (state == ST_REQ) begin
      req_o  = 1'b1;
      busy_o = 1'b1;
    end
  end

  // Selector moves only in IDLE; start takes priority and simultaneous inc+dec cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= '0;
    end else if (state == ST_IDLE && !start_ev) begin
      if (inc_ev && !dec_ev) begin
        if (sel == SEL_MAX) begin
          sel <= (SATURATE != 0) ? SEL_MAX : '0;
        end else begin
          sel <= sel + 1'b1;
        end
      end else if (dec_ev && !inc_ev) begin
        if (sel == '0) begin
          sel <= (SATURATE != 0) ? '0 : SEL_MAX;
        end else begin
          sel <= sel - 1'b1;
        end
      end
    end
  end

  // LED register: shows the captured result, or all lit after a timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      leds <= '1;
    end else if (state == ST_REQ) begin
      if (ack_i) begin
        leds <= ~result_i;
      end else if (timeout_hit) begin
        leds <= '0;
      end
    end
  end

  assign n_o      = sel;
  assign leds_n_o = leds;

endmodule
